// File: rtl/chunked_adder.sv
// Multi-cycle two's-complement adder/subtractor that adds CHUNK bits per clock through a registered carry.
// The operand registers shift right every RUN cycle, so the active chunk always sits in the low bits.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] chunkA, chunkB, chunkSum;
  logic [CHUNK:0]   carryChain;
  logic             chunkOvf;
  logic [WIDTH-1:0] opANext, opBNext, result;

  assign chunkA        = opA_q[CHUNK-1:0];
  assign chunkB        = opB_q[CHUNK-1:0];
  assign carryChain[0] = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : gSlice
    assign chunkSum[i]     = chunkA[i] ^ chunkB[i] ^ carryChain[i];
    assign carryChain[i+1] = (chunkA[i] & chunkB[i]) | (carryChain[i] & (chunkA[i] ^ chunkB[i]));
  end

  // Only meaningful on the final chunk, where slice CHUNK-1 is bit WIDTH-1.
  assign chunkOvf = carryChain[CHUNK] ^ carryChain[CHUNK-1];

  if (NCHUNK > 1) begin : gMulti
    logic [WIDTH-CHUNK-1:0] acc_q, acc_d;

    assign opANext = {{CHUNK{1'b0}}, opA_q[WIDTH-1:CHUNK]};
    assign opBNext = {{CHUNK{1'b0}}, opB_q[WIDTH-1:CHUNK]};
    assign result  = {chunkSum, acc_q};

    always_comb begin
      acc_d = acc_q;
      if (state_q == RUN) begin
        acc_d = result[WIDTH-1:CHUNK];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end else begin : gSingle
    assign opANext = '0;
    assign opBNext = '0;
    assign result  = chunkSum;
  end

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = a;
          opB_d   = sub ? ~b : b;
          carry_d = sub | cin;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opA_d   = opANext;
        opB_d   = opBNext;
        carry_d = carryChain[CHUNK];
        if (count_q == LAST) begin
          sum_d   = result;
          cout_d  = carryChain[CHUNK];
          ovf_d   = chunkOvf;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: four configurations share one stimulus stream and are checked every cycle
// against an arithmetic model; directed cases on the 16/4 instance pin the model to literal results.
module tb_chunked_adder;

  localparam int NI = 4;

  function automatic int cfgW(input int g);
    return (g == 3) ? 32 : 16;
  endfunction

  function automatic int cfgC(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int cfgN(input int g);
    return cfgW(g) / cfgC(g);
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          cin;
  logic          sub;
  logic [31:0]   aBus, bBus;
  logic [NI-1:0] readyV, doneV, coutV, ovfV;
  logic [31:0]   sumV [NI];

  for (genvar g = 0; g < NI; g++) begin : gDut
    localparam int W = cfgW(g);
    localparam int C = cfgC(g);
    logic [W-1:0] sumL;

    chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (aBus[W-1:0]),
      .b        (bBus[W-1:0]),
      .cin      (cin),
      .sub      (sub),
      .ready    (readyV[g]),
      .done     (doneV[g]),
      .sum      (sumL),
      .cout     (coutV[g]),
      .overflow (ovfV[g])
    );

    assign sumV[g] = 32'(sumL);
  end

  initial forever #5 clk = ~clk;

  function automatic longint maskOf(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sgn(input int w, input longint v);
    longint half = longint'(1) << (w - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic longint refSum(input int w, input logic [31:0] av, input logic [31:0] bv,
                                    input logic ci, input logic sb);
    longint x = longint'(av) & maskOf(w);
    longint y = longint'(bv) & maskOf(w);
    return sb ? ((x - y) & maskOf(w)) : ((x + y + longint'(ci)) & maskOf(w));
  endfunction

  function automatic bit refCout(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sb);
    longint x = longint'(av) & maskOf(w);
    longint y = longint'(bv) & maskOf(w);
    return sb ? (x >= y) : ((x + y + longint'(ci)) > maskOf(w));
  endfunction

  function automatic bit refOvf(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic ci, input logic sb);
    longint x    = longint'(av) & maskOf(w);
    longint y    = longint'(bv) & maskOf(w);
    longint half = longint'(1) << (w - 1);
    longint r    = sb ? (sgn(w, x) - sgn(w, y)) : (sgn(w, x) + sgn(w, y) + longint'(ci));
    return (r < -half) || (r >= half);
  endfunction

  // Model: an accepted op completes NCHUNK edges later; until then the unit is busy and ignores start.
  bit     mBusy [NI];
  int     mLeft [NI];
  longint pSum  [NI];
  bit     pCout [NI];
  bit     pOvf  [NI];
  longint mSum  [NI];
  bit     mCout [NI];
  bit     mOvf  [NI];
  bit     mDone [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NI; g++) begin
        mBusy[g] <= 1'b0;
        mLeft[g] <= 0;
        mSum[g]  <= 0;
        mCout[g] <= 1'b0;
        mOvf[g]  <= 1'b0;
        mDone[g] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        mDone[g] <= 1'b0;
        if (mBusy[g]) begin
          if (mLeft[g] == 1) begin
            mBusy[g] <= 1'b0;
            mDone[g] <= 1'b1;
            mSum[g]  <= pSum[g];
            mCout[g] <= pCout[g];
            mOvf[g]  <= pOvf[g];
          end else begin
            mLeft[g] <= mLeft[g] - 1;
          end
        end else if (start) begin
          mBusy[g] <= 1'b1;
          mLeft[g] <= cfgN(g);
          pSum[g]  <= refSum(cfgW(g), aBus, bBus, cin, sub);
          pCout[g] <= refCout(cfgW(g), aBus, bBus, cin, sub);
          pOvf[g]  <= refOvf(cfgW(g), aBus, bBus, cin, sub);
        end
      end
    end
  end

  int checks;
  int errors;
  int lat [NI];
  int readyLow;

  task automatic checkVal(input string tag, input int g, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %0h, expected %0h at %0t", tag, g, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    for (int g = 0; g < NI; g++) begin
      checkVal("ready", g, longint'(readyV[g]), longint'(!mBusy[g]));
      checkVal("done", g, longint'(doneV[g]), longint'(mDone[g]));
      checkVal("sum", g, longint'(sumV[g]), mSum[g]);
      checkVal("cout", g, longint'(coutV[g]), longint'(mCout[g]));
      checkVal("overflow", g, longint'(ovfV[g]), longint'(mOvf[g]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compareAll();
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 60; k++) begin
      if (&readyV) return;
      tick();
    end
    checkVal("idle timeout", 0, longint'(readyV), longint'({NI{1'b1}}));
  endtask

  // Launches one op on all instances, scrambles the inputs while it is in flight, records latencies.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    bit seen [NI];
    bit allSeen;
    waitIdle();
    aBus  = av;
    bBus  = bv;
    cin   = ci;
    sub   = sb;
    start = 1'b1;
    for (int g = 0; g < NI; g++) begin
      lat[g]  = -1;
      seen[g] = 1'b0;
    end
    readyLow = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start = 1'b0;
      for (int g = 0; g < NI; g++) begin
        if (!seen[g] && doneV[g]) begin
          seen[g] = 1'b1;
          lat[g]  = k - 1;
        end
      end
      if (!seen[1] && !readyV[1]) readyLow++;
      aBus = $urandom;
      bBus = $urandom;
      cin  = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      allSeen = 1'b1;
      for (int g = 0; g < NI; g++) allSeen &= seen[g];
      if (allSeen) break;
    end
  endtask

  task automatic checkOutput(input string name, input longint s, input bit co, input bit ov);
    checkVal({name, " sum"}, 1, longint'(sumV[1]), s);
    checkVal({name, " cout"}, 1, longint'(coutV[1]), longint'(co));
    checkVal({name, " overflow"}, 1, longint'(ovfV[1]), longint'(ov));
    checkVal({name, " latency"}, 1, longint'(lat[1]), 4);
  endtask

  int pulses1, pulses2, stray;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    aBus   = '0;
    bBus   = '0;
    cin    = 1'b0;
    sub    = 1'b0;
    repeat (3) tick();
    checkVal("reset ready", 1, longint'(readyV[1]), 1);
    checkVal("reset done", 1, longint'(doneV[1]), 0);
    checkVal("reset sum", 1, longint'(sumV[1]), 0);
    checkVal("reset overflow", 1, longint'(ovfV[1]), 0);
    rst_n = 1'b1;

    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("wrap", 64'h0000, 1'b1, 1'b0);
    checkVal("wrap ready low cycles", 1, longint'(readyLow), 4);
    applyStimulus(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("signed ovf", 64'h8000, 1'b0, 1'b1);
    applyStimulus(32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("cin", 64'h1235, 1'b0, 1'b0);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    checkOutput("sub borrow", 64'hFFFE, 1'b0, 1'b0);
    applyStimulus(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
    checkOutput("sub ovf", 64'h7FFF, 1'b1, 1'b1);

    // Start held high with operands changing every cycle.
    waitIdle();
    start   = 1'b1;
    pulses1 = 0;
    pulses2 = 0;
    for (int k = 1; k <= 50; k++) begin
      aBus = $urandom;
      bBus = $urandom;
      cin  = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      tick();
      if (doneV[1]) pulses1++;
      if (doneV[2]) pulses2++;
    end
    start = 1'b0;
    checkVal("held-start pulses", 1, longint'(pulses1), 10);
    checkVal("held-start pulses", 2, longint'(pulses2), 25);

    // Reset after the second RUN edge of an op.
    waitIdle();
    aBus  = 32'h0000_00FF;
    bBus  = 32'h0000_0001;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checkVal("abort ready", 1, longint'(readyV[1]), 1);
    checkVal("abort done", 1, longint'(doneV[1]), 0);
    checkVal("abort sum", 1, longint'(sumV[1]), 0);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (doneV[1]) stray++;
    end
    checkVal("stray done", 1, longint'(stray), 0);
    applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    checkOutput("after abort", 64'h0007, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int g = 0; g < NI; g++) begin
        checkVal("random latency", g, longint'(lat[g]), longint'(cfgN(g)));
      end
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
